// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - SRAM-like bus responder with in-order fixed-latency responses
// Optional stall injection: define SRAM_LIKE_STALL_INJECT_EN.
module sram_like_responder #(
    parameter int          ADDR_WIDTH      = 12,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int QSLOTS = 16;
    localparam int QW     = 4;
    localparam int CW     = 5;
    localparam logic [QW-1:0] LAST_SLOT = QW'(MAX_OUTSTANDING - 1);
    localparam logic [QW-1:0] POP_AGE   = QW'(LATENCY - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic [3:0]            be;
    logic                  req_err;
    logic                  accept;
    logic                  pop;
    logic                  stall;
    logic [31:0]           rd_word;

    logic                  q_is_rd [QSLOTS];
    logic                  q_err   [QSLOTS];
    logic [31:0]           q_rdata [QSLOTS];
    logic [QW-1:0]         q_age   [QSLOTS];

    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          data_ok_q;
    logic [31:0]   rdata_q;
    logic          resp_err_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign widx    = addr[ADDR_WIDTH+1:2];
    assign rd_word = mem[widx];

    always_comb begin
        be      = 4'b0000;
        req_err = 1'b0;
        case (size)
            2'd0: be = 4'b0001 << addr[1:0];
            2'd1: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                req_err = addr[0];
            end
            2'd2: begin
                be      = 4'b1111;
                req_err = (addr[1:0] != 2'b00);
            end
            default: req_err = 1'b1;
        endcase
    end

`ifdef SRAM_LIKE_STALL_INJECT_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_q <= STALL_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Gated by the registered count only, so req never feeds back into addr_ok.
    assign addr_ok = resetn && (outstanding_q < MAX_CNT) && !stall;
    assign accept  = req && addr_ok;
    assign pop     = (q_cnt_q != '0) && (q_age[rd_ptr_q] == POP_AGE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        q_cnt_d       = q_cnt_q + {4'b0, accept} - {4'b0, pop};
        outstanding_d = outstanding_q + {4'b0, accept} - {4'b0, data_ok_q};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            q_cnt_q       <= '0;
            outstanding_q <= '0;
            data_ok_q     <= 1'b0;
            rdata_q       <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            q_cnt_q       <= q_cnt_d;
            outstanding_q <= outstanding_d;
            data_ok_q     <= pop;
            if (pop) begin
                rdata_q    <= q_is_rd[rd_ptr_q] ? q_rdata[rd_ptr_q] : '0;
                resp_err_q <= q_err[rd_ptr_q];
            end
        end
    end

    // Payload and ages need no reset: only slots counted by q_cnt_q are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QSLOTS; i++) begin
            q_age[i] <= q_age[i] + 4'd1;
        end
        if (accept) begin
            q_is_rd[wr_ptr_q] <= !wr;
            q_err[wr_ptr_q]   <= req_err;
            q_rdata[wr_ptr_q] <= req_err ? '0 : rd_word;
            q_age[wr_ptr_q]   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wr && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok  = data_ok_q;
    assign rdata    = rdata_q;
    assign resp_err = resp_err_q;
    assign busy     = (outstanding_q != '0);

endmodule

// File: tb/tb_sram_like_responder.sv
// tb/tb_sram_like_responder.sv - bench for sram_like_responder (two configurations, one shared reset)
module tb_sram_like_responder;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req [2];
    logic        wr [2];
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata [2];
    logic        resp_err [2];
    logic        busy [2];

    int errs   = 0;
    int checks = 0;

    sram_like_responder #(.LATENCY(1), .MAX_OUTSTANDING(4)) u_dut_a (
        .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
        .rdata(rdata[0]), .resp_err(resp_err[0]), .busy(busy[0]));

    sram_like_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
        .rdata(rdata[1]), .resp_err(resp_err[1]), .busy(busy[1]));

    always #5 clk = ~clk;

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int maxo(int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // Model: every accepted request is remembered with its accept edge number.
    typedef struct {
        int          k;
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd [2];
    logic        last_er [2];
    logic [15:0] lfsr_m;
    int          ecnt    = 0;
    bit          started = 0;

    function automatic bit stalled(logic [15:0] l);
`ifdef SRAM_LIKE_STALL_INJECT_EN
        return (l[1:0] == 2'b00);
`else
        return 1'b0 && (l == l);
`endif
    endfunction

    // Requests still owed a response (or in their data_ok cycle) after edge e.
    function automatic int win(int k, int e);
        int n = 0;
        foreach (q[i]) if (q[i].k == k && q[i].cyc >= e - lat(k) && q[i].cyc <= e) n++;
        return n;
    endfunction

    function automatic int due(int k, int e);
        foreach (q[i]) if (q[i].k == k && q[i].cyc == e - lat(k)) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int k);
        ent_t        e;
        int          off;
        int          key;
        bit          err;
        logic [31:0] old;
        bit [3:0]    lanes;
        off   = int'(addr[k][1:0]);
        err   = 0;
        lanes = 4'b0000;
        case (size[k])
            2'd0: lanes[off] = 1'b1;
            2'd1: begin
                err = (off % 2) != 0;
                lanes[off - (off % 2)]     = 1'b1;
                lanes[off - (off % 2) + 1] = 1'b1;
            end
            2'd2: begin
                err   = off != 0;
                lanes = 4'b1111;
            end
            default: err = 1;
        endcase
        key = k * 65536 + int'(addr[k][13:2]);
        old = mem_m.exists(key) ? mem_m[key] : 32'h0;
        e.k     = k;
        e.cyc   = ecnt;
        e.err   = err;
        e.rdata = (!wr[k] && !err) ? old : 32'h0;
        if (wr[k] && !err) begin
            for (int b = 0; b < 4; b++) if (lanes[b]) old[8*b +: 8] = wdata[k][8*b +: 8];
            mem_m[key] = old;
        end
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        ecnt++;
        if (!resetn) begin
            q.delete();
            last_rd = '{32'h0, 32'h0};
            last_er = '{1'b0, 1'b0};
            lfsr_m  = 16'hACE1;
            started = 1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (req[k] && win(k, ecnt - 1) < maxo(k) && !stalled(lfsr_m)) model_accept(k);
            end
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc < ecnt - lat(q[i].k) - 1) q.delete(i);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                int idx;
                bit exp_aok;
                idx     = due(k, ecnt);
                exp_aok = resetn && (win(k, ecnt) < maxo(k)) && !stalled(lfsr_m);
                if (idx >= 0) begin
                    last_rd[k] = q[idx].rdata;
                    last_er[k] = q[idx].err;
                end
                chk($sformatf("addr_ok[%0d]", k), {31'h0, addr_ok[k]}, {31'h0, exp_aok});
                chk($sformatf("data_ok[%0d]", k), {31'h0, data_ok[k]}, {31'h0, idx >= 0});
                chk($sformatf("busy[%0d]", k), {31'h0, busy[k]}, {31'h0, win(k, ecnt) != 0});
                chk($sformatf("rdata[%0d]", k), rdata[k], last_rd[k]);
                chk($sformatf("resp_err[%0d]", k), {31'h0, resp_err[k]}, {31'h0, last_er[k]});
            end
        end
    end

    task automatic xact(input int k, input bit w, input bit [1:0] s, input bit [31:0] a, input bit [31:0] d);
        bit ok = 0;
        req[k] = 1'b1; wr[k] = w; size[k] = s; addr[k] = a; wdata[k] = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (addr_ok[k] === 1'b1) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL handshake[%0d]: addr_ok got 0 for 200 cycles, required 1", k);
        end
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output logic [31:0] rd, output logic er, output int lt);
        lt = 0; rd = 32'h0; er = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (data_ok[k] === 1'b1) begin
                rd = rdata[k];
                er = resp_err[k];
                lt = n;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        logic [7:0]  pat;
        int          dok_seen;

        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; wr[k] = 0; size[k] = 0; addr[k] = 0; wdata[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset addr_ok", {31'h0, addr_ok[0]}, 32'h0);
        chk("reset data_ok", {31'h0, data_ok[0]}, 32'h0);
        chk("reset rdata", rdata[1], 32'h0);
        chk("reset busy", {31'h0, busy[1]}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Write then read back, latency 1
        xact(0, 1, 2, 32'h10, 32'hDEADBEEF);
        wait_rsp(0, rd, er, lt);
        chk("t1 write latency", lt, 2);
        chk("t1 write rdata", rd, 32'h0);
        xact(0, 0, 2, 32'h10, 32'h0);
        wait_rsp(0, rd, er, lt);
        chk("t1 read latency", lt, 2);
        chk("t1 read rdata", rd, 32'hDEADBEEF);
        chk("t1 read err", {31'h0, er}, 32'h0);

        // Byte and half-word lane writes
        xact(0, 1, 2, 32'h10, 32'h11223344); wait_rsp(0, rd, er, lt);
        xact(0, 1, 0, 32'h13, 32'hAAAAAAAA); wait_rsp(0, rd, er, lt);
        xact(0, 0, 2, 32'h10, 32'h0);        wait_rsp(0, rd, er, lt);
        chk("t2 byte lane", rd, 32'hAA223344);
        xact(0, 1, 1, 32'h12, 32'hBEEFBEEF); wait_rsp(0, rd, er, lt);
        xact(0, 0, 0, 32'h11, 32'h0);        wait_rsp(0, rd, er, lt);
        chk("t2 half lane", rd, 32'hBEEF3344);

        // Illegal / misaligned requests
        xact(0, 0, 2, 32'h02, 32'h0); wait_rsp(0, rd, er, lt);
        chk("t4 misaligned word err", {31'h0, er}, 32'h1);
        chk("t4 misaligned word rdata", rd, 32'h0);
        xact(0, 1, 3, 32'h10, 32'hFFFFFFFF); wait_rsp(0, rd, er, lt);
        chk("t4 size3 err", {31'h0, er}, 32'h1);
        xact(0, 1, 1, 32'h11, 32'h55555555); wait_rsp(0, rd, er, lt);
        chk("t4 misaligned half err", {31'h0, er}, 32'h1);
        xact(0, 0, 2, 32'h10, 32'h0); wait_rsp(0, rd, er, lt);
        chk("t4 memory unchanged", rd, 32'hBEEF3344);

        // Latency 3, two slots, req held high
        xact(1, 1, 2, 32'h10, 32'h0BADF00D); wait_rsp(1, rd, er, lt);
        chk("t3 latency", lt, 4);
        idle(3);
        req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h10;
        pat = 8'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat = {pat[6:0], addr_ok[1]};
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
`ifndef SRAM_LIKE_STALL_INJECT_EN
        chk("t3 addr_ok pattern", {24'h0, pat}, 32'h000000C6);
`endif
        idle(12);

        // Reset with two reads in flight
        xact(1, 0, 2, 32'h10, 32'h0);
        xact(1, 0, 2, 32'h10, 32'h0);
        resetn   = 1'b0;
        dok_seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dok_seen += int'(data_ok[1]);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dok_seen += int'(data_ok[1]);
            if (i < 7) begin
                @(posedge clk); #1;
            end
        end
        chk("t5 dropped responses", dok_seen, 0);
        chk("t5 busy after reset", {31'h0, busy[1]}, 32'h0);
`ifndef SRAM_LIKE_STALL_INJECT_EN
        chk("t5 addr_ok after reset", {31'h0, addr_ok[1]}, 32'h1);
`endif
        @(posedge clk); #1;
        xact(0, 0, 2, 32'h10, 32'h0); wait_rsp(0, rd, er, lt);
        chk("t5 memory retained a", rd, 32'hBEEF3344);
        xact(1, 0, 2, 32'h10, 32'h0); wait_rsp(1, rd, er, lt);
        chk("t5 memory retained b", rd, 32'h0BADF00D);

        // Pipelined mixed traffic over a pre-written window
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 8; w++) xact(k, 1, 2, 32'h100 + 32'(4 * w), $urandom);
        end
        idle(6);
        for (int n = 0; n < 300; n++) begin
            xact($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 32'h100 + 32'($urandom_range(0, 31)), $urandom);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
